// File: rtl/shift_ctrl_pkg.sv
// rtl/shift_ctrl_pkg.sv - shared states, defaults and width helper for the shift controller
package shift_ctrl_pkg;

  localparam int N_DEFAULT   = 4;
  localparam int GAP_DEFAULT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Smallest width able to hold values 0..v-1; never below 1 bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/shift_ctrl_piso_core.sv
// rtl/shift_ctrl_piso_core.sv - parallel-load / serial-shift register, MSB first
module shift_ctrl_piso_core
  import shift_ctrl_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift_en,
  input  logic [N-1:0] load_data,
  output logic         msb_out
);

  logic [N-1:0] shreg_q;
  logic [N-1:0] shreg_d;

  // Load wins over shift; shifting pulls zeros in from the bottom.
  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = load_data;
    end else if (shift_en) begin
      shreg_d = {shreg_q[N-2:0], 1'b0};
    end
  end

  // Shift register storage, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) shreg_q <= '0;
    else      shreg_q <= shreg_d;
  end

  assign msb_out = shreg_q[N-1];

endmodule

// File: rtl/shift_ctrl_serializer.sv
// rtl/shift_ctrl_serializer.sv - frame sequencer for the PISO datapath; SHIFT_CTRL_PARITY_EN appends an even-parity bit
module shift_ctrl_serializer
  import shift_ctrl_pkg::*;
#(
  parameter int N   = N_DEFAULT,
  parameter int GAP = GAP_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         sout,
  output logic         sout_valid,
  output logic         frame_start,
  output logic         frame_end,
  output logic         busy
);

`ifdef SHIFT_CTRL_PARITY_EN
  localparam int LAST = N;
`else
  localparam int LAST = N - 1;
`endif
  localparam int                CNT_W    = clog2(LAST + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LAST);
  localparam logic [3:0]        GAP_INIT = 4'((GAP > 0) ? GAP - 1 : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gcnt_q, gcnt_d;
  logic             load, shift_en, msb;
  logic             data_bit;

  shift_ctrl_piso_core #(.N(N)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .shift_en  (shift_en),
    .load_data (in_data),
    .msb_out   (msb)
  );

`ifdef SHIFT_CTRL_PARITY_EN
  logic par_q, par_d;

  // Parity of the accepted word, held for the trailing bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_q <= 1'b0;
    else      par_q <= par_d;
  end

  // The extra bit slot beyond the data word carries the parity.
  always_comb begin
    par_d    = load ? ^in_data : par_q;
    data_bit = (cnt_q == CNT_W'(N)) ? par_q : msb;
  end
`else
  assign data_bit = msb;
`endif

  // State and counters, cleared asynchronously so a frame aborts at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // Next-state logic and datapath controls.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gcnt_d   = gcnt_q;
    load     = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (GAP > 0) begin
            gcnt_d  = GAP_INIT;
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gcnt_q == 4'd0) state_d = ST_IDLE;
        else                gcnt_d  = gcnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode from registered state only.
  always_comb begin
    in_ready    = (state_q == ST_IDLE);
    busy        = (state_q == ST_SHIFT) || (state_q == ST_GAP);
    sout_valid  = (state_q == ST_SHIFT);
    sout        = (state_q == ST_SHIFT) && data_bit;
    frame_start = (state_q == ST_SHIFT) && (cnt_q == '0);
    frame_end   = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
  end

endmodule

// File: tb/tb_shift_ctrl_serializer.sv
// tb/tb_shift_ctrl_serializer.sv - randomized and directed bench with a schedule-based reference model
module tb_shift_ctrl_serializer;

  localparam int N   = 4;
  localparam int GAP = 1;
`ifdef SHIFT_CTRL_PARITY_EN
  localparam int FL  = N + 1;
`else
  localparam int FL  = N;
`endif
  localparam int PERIOD = FL + 1 + GAP;

  // record layout: {in_ready, busy, sout, sout_valid, frame_start, frame_end}
  localparam logic [5:0] IDLE_REC = 6'b100000;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       sout, sout_valid, frame_start, frame_end, busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  logic [5:0] sched[$];

  shift_ctrl_serializer #(.N(N), .GAP(GAP)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .sout        (sout),
    .sout_valid  (sout_valid),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .busy        (busy)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle outputs of one whole frame plus its gap.
  task automatic push_frame(input logic [3:0] w);
    for (int i = 0; i < N; i++)
      sched.push_back({1'b0, 1'b1, w[N-1-i], 1'b1, (i == 0), (i == FL - 1)});
`ifdef SHIFT_CTRL_PARITY_EN
    sched.push_back({1'b0, 1'b1, ^w, 1'b1, 1'b0, 1'b1});
`endif
    for (int i = 0; i < GAP; i++)
      sched.push_back(6'b010000);
  endtask

  always @(negedge rst) sched.delete();

  // Model advance: an empty schedule means idle and willing to accept.
  always @(posedge clk) begin
    if (!rst) sched.delete();
    else if (sched.size() == 0) begin
      if (in_valid) push_frame(in_data);
    end else begin
      void'(sched.pop_front());
    end
  end

  // Cycle compare against the model.
  always @(negedge clk) begin
    logic [5:0] exp_rec, act_rec;
    if (chk_en && rst) begin
      exp_rec = (sched.size() != 0) ? sched[0] : IDLE_REC;
      act_rec = {in_ready, busy, sout, sout_valid, frame_start, frame_end};
      chk("model_cycle", {10'd0, act_rec}, {10'd0, exp_rec});
    end
  end

  task automatic send(input logic [3:0] w, input bit hold);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("send_ready", {15'd0, in_ready}, 16'd1);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic capture(input int n, input bit scramble, output logic [15:0] bits,
                         output logic [15:0] starts, output logic [15:0] ends);
    bits = '0; starts = '0; ends = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bits   = {bits[14:0], sout};
      starts = {starts[14:0], frame_start};
      ends   = {ends[14:0], frame_end};
      if (scramble) begin
        in_data  = 4'($urandom);
        in_valid = 1'($urandom);
      end
    end
  endtask

  initial begin
    logic [15:0] b, s, e, vb;
    int first_fs, second_fs, nv;
    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0;

    // Reset state.
    #5 rst = 1'b0;
    #1;
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("rst_sout", {15'd0, sout}, 16'd0);
    chk("rst_sout_valid", {15'd0, sout_valid}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    #9 rst = 1'b1;
    #1;
    chk("post_rst_idle", {10'd0, in_ready, busy, sout, sout_valid, frame_start, frame_end},
        {10'd0, IDLE_REC});
    chk_en = 1;

    // Single word.
`ifdef SHIFT_CTRL_PARITY_EN
    send(4'b0111, 0);
    capture(FL, 0, b, s, e);
    chk("single_bits", b, 16'b01111);
    chk("single_start", s, 16'b10000);
    chk("single_end", e, 16'b00001);
`else
    send(4'b1011, 0);
    capture(FL, 0, b, s, e);
    chk("single_bits", b, 16'b1011);
    chk("single_start", s, 16'b1000);
    chk("single_end", e, 16'b0001);
`endif
    @(negedge clk);
    chk("single_gap", {14'd0, busy, sout_valid}, 16'b10);
    @(negedge clk);
    chk("single_ready", {15'd0, in_ready}, 16'd1);

    // Back-to-back with in_valid held.
    in_valid = 1'b1; in_data = 4'hA;
    @(posedge clk); #1 in_data = 4'h5;
    first_fs = -1; second_fs = -1; vb = '0; nv = 0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk);
      if (frame_start && first_fs < 0) first_fs = i;
      else if (frame_start && second_fs < 0) second_fs = i;
      if (sout_valid) begin vb = {vb[14:0], sout}; nv++; end
    end
    in_valid = 1'b0;
    chk("b2b_period", 16'(second_fs - first_fs), 16'(PERIOD));
    chk("b2b_nbits", 16'(nv), 16'(2 * FL));
`ifdef SHIFT_CTRL_PARITY_EN
    chk("b2b_bits", vb, 16'b1010001010);
`else
    chk("b2b_bits", vb, 16'b10100101);
`endif

    // Inputs toggled during SHIFT are ignored.
    send(4'hC, 0);
    capture(FL, 1, b, s, e);
    in_valid = 1'b0;
`ifdef SHIFT_CTRL_PARITY_EN
    chk("ignore_bits", b, 16'b11000);
`else
    chk("ignore_bits", b, 16'b1100);
`endif

    // Reset in the middle of a frame.
    send(4'hF, 0);
    capture(2, 0, b, s, e);
    chk("mid_bits", b, 16'b11);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_outs", {12'd0, sout_valid, sout, busy, in_ready}, 16'b0001);
    @(negedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_no_residue", {14'd0, sout_valid, in_ready}, 16'b01);
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 4'($urandom);
    end
    in_valid = 1'b0;
    repeat (PERIOD + 2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
